wb_stage: RTL and testbench

- Sixth and final pipeline stage. Receives the memory-stage bus and performs load-data lane extraction with sign or zero extension.
- Selects the register-file write data, drives the register-file write port and the bypass bus.
- Pushes one debug-trace record per retired instruction into a small FIFO drained by a valid/ready trace consumer.
- A full trace FIFO back-pressures the pipeline through WB_allow_in.

---
 rtl/wb_stage_pkg.sv | 36 +++
 rtl/wb_trace_fifo.sv | 70 +++++++
 rtl/wb_stage.sv | 133 +++++++++++++
 tb/tb_wb_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared widths, byte-enable codes and record layouts for the write-back stage.
// Bus and trace layouts are MSB-first, matching the upstream memory stage.
package wb_stage_pkg;

    localparam int MEM_TO_WB_BUS_WD = 111;
    localparam int WB_TO_BY_BUS_WD  = 39;
    localparam int TRACE_REC_WD     = 73;

    localparam logic [3:0] BEN_B0 = 4'b0001;
    localparam logic [3:0] BEN_B1 = 4'b0010;
    localparam logic [3:0] BEN_B2 = 4'b0100;
    localparam logic [3:0] BEN_B3 = 4'b1000;
    localparam logic [3:0] BEN_H0 = 4'b0011;
    localparam logic [3:0] BEN_H1 = 4'b1100;
    localparam logic [3:0] BEN_W  = 4'b1111;

    typedef struct packed {
        logic [2:0]  sel_rf_w_data_valid_stage;
        logic        sel_rf_w_en;
        logic        sel_rf_w_data;
        logic        sel_data_ram_wd;
        logic [3:0]  data_ram_b_en;
        logic [31:0] data_ram_r_data;
        logic [4:0]  regfile_w_addr;
        logic [31:0] alu_result;
        logic [31:0] inst_pc;
    } mem_to_wb_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rf_we;
        logic [4:0]  rf_wnum;
        logic [31:0] rf_wdata;
    } trace_rec_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Small synchronous FIFO with occupancy count and a registered head entry.
// The head register is refreshed from the post-update storage so a push into empty shows next cycle.
module wb_trace_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = wr_q + PW'(1);
        end
        if (pop_i) begin
            rd_d = rd_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Depth is a power of two, so pointer wrap is the natural overflow.
        head_d = mem_d[rd_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign head_o  = head_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/wb_stage.sv
// Final pipeline stage: load lane extraction, register-file write, bypass bus and retire trace.
// A full trace FIFO with no same-cycle pop holds the instruction in WB and closes WB_allow_in.
import wb_stage_pkg::*;

module wb_stage #(
    parameter int TRACE_EN    = 1,
    parameter int TRACE_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
    input  logic                        MEM_to_WB_valid,
    output logic                        WB_allow_in,
    output logic                        rf_w_en,
    output logic [4:0]                  rf_w_addr,
    output logic [31:0]                 rf_w_data,
    output logic [WB_TO_BY_BUS_WD-1:0]  WB_to_BY_bus,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [31:0]                 trace_pc,
    output logic [3:0]                  trace_rf_we,
    output logic [4:0]                  trace_rf_wnum,
    output logic [31:0]                 trace_rf_wdata
);

    // Handshake: upstream offers MEM_to_WB_valid; a transfer happens on a
    // rising edge where MEM_to_WB_valid & WB_allow_in. Trace records move on
    // trace_valid & trace_ready; trace_valid never depends on trace_ready.
    logic       wb_valid_q, wb_valid_d;
    mem_to_wb_t bus_q, bus_d;
    logic       ready_go;
    logic       retire;
    logic [31:0] ld_word;
    logic [31:0] ld_data;
    logic        ld_sign;
    logic        unused_bits;

    assign WB_allow_in = ~wb_valid_q | ready_go;
    assign retire      = wb_valid_q & ready_go;

    always_comb begin
        wb_valid_d = wb_valid_q;
        bus_d      = bus_q;
        if (WB_allow_in) begin
            wb_valid_d = MEM_to_WB_valid;
        end
        if (WB_allow_in && MEM_to_WB_valid) begin
            bus_d = mem_to_wb_t'(MEM_to_WB_bus);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            bus_q      <= bus_d;
        end
    end

    assign ld_word = bus_q.data_ram_r_data;
    assign ld_sign = bus_q.sel_data_ram_wd;

    always_comb begin
        ld_data = ld_word;
        case (bus_q.data_ram_b_en)
            BEN_B0:  ld_data = {{24{ld_sign & ld_word[7]}},  ld_word[7:0]};
            BEN_B1:  ld_data = {{24{ld_sign & ld_word[15]}}, ld_word[15:8]};
            BEN_B2:  ld_data = {{24{ld_sign & ld_word[23]}}, ld_word[23:16]};
            BEN_B3:  ld_data = {{24{ld_sign & ld_word[31]}}, ld_word[31:24]};
            BEN_H0:  ld_data = {{16{ld_sign & ld_word[15]}}, ld_word[15:0]};
            BEN_H1:  ld_data = {{16{ld_sign & ld_word[31]}}, ld_word[31:16]};
            default: ld_data = ld_word;
        endcase
    end

    assign rf_w_data = bus_q.sel_rf_w_data ? ld_data : bus_q.alu_result;
    assign rf_w_addr = bus_q.regfile_w_addr;
    assign rf_w_en   = retire & bus_q.sel_rf_w_en & (bus_q.regfile_w_addr != 5'd0);

    // Raw valid lets bypass see a stalled result; every value is final here.
    assign WB_to_BY_bus = {wb_valid_q, rf_w_en, rf_w_addr, rf_w_data};
    assign unused_bits  = ^bus_q.sel_rf_w_data_valid_stage;

    if (TRACE_EN != 0) begin : g_trace
        trace_rec_t                push_rec;
        trace_rec_t                head_rec;
        logic [TRACE_REC_WD-1:0]   head_bits;
        logic                      fifo_empty;
        logic                      fifo_full;
        logic                      pop;

        assign push_rec = '{pc:       bus_q.inst_pc,
                            rf_we:    {4{rf_w_en}},
                            rf_wnum:  bus_q.regfile_w_addr,
                            rf_wdata: rf_w_data};
        assign pop      = ~fifo_empty & trace_ready;
        assign ready_go = ~fifo_full | trace_ready;

        wb_trace_fifo #(
            .DEPTH (TRACE_DEPTH),
            .WIDTH (TRACE_REC_WD)
        ) u_trace_fifo (
            .clk         (clk),
            .rst_n       (reset),
            .push_i      (retire),
            .push_data_i (push_rec),
            .pop_i       (pop),
            .head_o      (head_bits),
            .empty_o     (fifo_empty),
            .full_o      (fifo_full)
        );

        assign head_rec       = trace_rec_t'(head_bits);
        assign trace_valid    = ~fifo_empty;
        assign trace_pc       = head_rec.pc;
        assign trace_rf_we    = head_rec.rf_we;
        assign trace_rf_wnum  = head_rec.rf_wnum;
        assign trace_rf_wdata = head_rec.rf_wdata;
    end else begin : g_no_trace
        logic unused_ready;

        assign unused_ready   = trace_ready;
        assign ready_go       = 1'b1;
        assign trace_valid    = 1'b0;
        assign trace_pc       = '0;
        assign trace_rf_we    = '0;
        assign trace_rf_wnum  = '0;
        assign trace_rf_wdata = '0;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomised and directed bench for wb_stage with a queue scoreboard fed at issue time.
// A negedge monitor pops expected register writes and trace records as the DUT presents them.
module tb_wb_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic        we_sel;
        logic        dsel;
        logic        sgn;
        logic [3:0]  ben;
        logic [31:0] rdata;
        logic [4:0]  addr;
        logic [31:0] alu;
    } instr_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [110:0] MEM_to_WB_bus;
    logic         MEM_to_WB_valid;
    logic         WB_allow_in;
    logic         rf_w_en;
    logic [4:0]   rf_w_addr;
    logic [31:0]  rf_w_data;
    logic [38:0]  WB_to_BY_bus;
    logic         trace_valid;
    logic         trace_ready;
    logic [31:0]  trace_pc;
    logic [3:0]   trace_rf_we;
    logic [4:0]   trace_rf_wnum;
    logic [31:0]  trace_rf_wdata;

    logic [36:0]  exp_rf_q[$];
    logic [72:0]  exp_tr_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           ready_mode = 1;

    always #5 clk = ~clk;

    wb_stage #(
        .TRACE_EN    (1),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .MEM_to_WB_bus   (MEM_to_WB_bus),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .WB_allow_in     (WB_allow_in),
        .rf_w_en         (rf_w_en),
        .rf_w_addr       (rf_w_addr),
        .rf_w_data       (rf_w_data),
        .WB_to_BY_bus    (WB_to_BY_bus),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .trace_pc        (trace_pc),
        .trace_rf_we     (trace_rf_we),
        .trace_rf_wnum   (trace_rf_wnum),
        .trace_rf_wdata  (trace_rf_wdata)
    );

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics: pick a lane by shift and width, then extend.
    function automatic logic [31:0] model_load(input logic [3:0] ben, input logic [31:0] word,
                                               input logic sgn);
        int          lo;
        int          w;
        logic [31:0] mask;
        logic [31:0] v;
        case (ben)
            4'b0001: begin lo = 0;  w = 8;  end
            4'b0010: begin lo = 8;  w = 8;  end
            4'b0100: begin lo = 16; w = 8;  end
            4'b1000: begin lo = 24; w = 8;  end
            4'b0011: begin lo = 0;  w = 16; end
            4'b1100: begin lo = 16; w = 16; end
            default: return word;
        endcase
        mask = (32'h1 << w) - 32'h1;
        v    = (word >> lo) & mask;
        if (sgn && v[w-1]) begin
            v = v | ~mask;
        end
        return v;
    endfunction

    // Offer one instruction until accepted; expectations are queued on acceptance.
    task automatic issue(input instr_t in, input logic use_exp, input logic [31:0] exp_data);
        logic [31:0] data;
        logic        we;
        logic        acc;
        int          budget;
        data = use_exp ? exp_data : (in.dsel ? model_load(in.ben, in.rdata, in.sgn) : in.alu);
        we   = in.we_sel && (in.addr != 5'd0);
        MEM_to_WB_bus   = {3'($urandom_range(0, 7)), in.we_sel, in.dsel, in.sgn, in.ben,
                           in.rdata, in.addr, in.alu, in.pc};
        MEM_to_WB_valid = 1'b1;
        acc    = 1'b0;
        budget = 200;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = WB_allow_in;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: pc %0h never accepted", in.pc);
        end else begin
            if (we) exp_rf_q.push_back({in.addr, data});
            exp_tr_q.push_back({in.pc, (we ? 4'hF : 4'h0), in.addr, data});
        end
        MEM_to_WB_valid = 1'b0;
    endtask

    function automatic instr_t rand_instr(input int idx);
        instr_t      r;
        logic [3:0]  codes [8];
        codes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};
        r.pc     = 32'h2000_0000 + 32'(idx * 4);
        r.we_sel = ($urandom_range(0, 7) != 0);
        r.dsel   = $urandom_range(0, 1) == 1;
        r.sgn    = $urandom_range(0, 1) == 1;
        r.ben    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                               : codes[$urandom_range(0, 7)];
        r.rdata  = $urandom;
        r.addr   = 5'($urandom_range(0, 31));
        r.alu    = $urandom;
        return r;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic dsel, input logic sgn,
                                  input logic [3:0] ben, input logic [4:0] addr,
                                  input logic [31:0] alu);
        instr_t r;
        r.pc = pc; r.we_sel = 1'b1; r.dsel = dsel; r.sgn = sgn; r.ben = ben;
        r.rdata = 32'h80FF_7F01; r.addr = addr; r.alu = alu;
        return r;
    endfunction

    initial begin
        trace_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       trace_ready = ($urandom_range(0, 2) != 0);
                2:       trace_ready = 1'b0;
                default: trace_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [36:0] e_rf;
        logic [72:0] e_tr;
        if (reset) begin
            if (rf_w_en) begin
                if (exp_rf_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rf_unexpected: addr %0h data %0h", rf_w_addr, rf_w_data);
                end else begin
                    e_rf = exp_rf_q.pop_front();
                    check("rf_write", 73'({rf_w_addr, rf_w_data}), 73'(e_rf));
                    check("by_bus", 73'(WB_to_BY_bus), 73'({2'b11, e_rf}));
                end
            end
            if (trace_valid && trace_ready) begin
                if (exp_tr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL trace_unexpected: pc %0h", trace_pc);
                end else begin
                    e_tr = exp_tr_q.pop_front();
                    check("trace_rec", {trace_pc, trace_rf_we, trace_rf_wnum, trace_rf_wdata}, e_tr);
                end
            end
        end
    end

    initial begin
        logic [31:0] ld_exp [9];
        logic [3:0]  ld_ben [9];
        logic        ld_sgn [9];
        int          budget;

        reset = 1'b0;
        MEM_to_WB_valid = 1'b0;
        MEM_to_WB_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_allow_in", 73'(WB_allow_in), 73'(1));
        check("rst_rf_w_en", 73'(rf_w_en), 73'(0));
        check("rst_rf_w_data", 73'(rf_w_data), 73'(0));
        check("rst_by_bus", 73'(WB_to_BY_bus), 73'(0));
        check("rst_trace_valid", 73'(trace_valid), 73'(0));
        check("rst_trace_head", {trace_pc, trace_rf_we, trace_rf_wnum, trace_rf_wdata}, 73'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU write with cycle-accurate latency checks.
        issue(mk(32'h1000_0000, 1'b0, 1'b0, 4'b1111, 5'd5, 32'h1234_5678), 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("alu_rf_w_en_latency", 73'(rf_w_en), 73'(1));
        check("alu_rf_w_data", 73'(rf_w_data), 73'(32'h1234_5678));
        @(negedge clk);
        check("alu_trace_next_cycle", 73'({trace_valid, trace_pc}), 73'({1'b1, 32'h1000_0000}));
        @(posedge clk);
        #1;

        // Load lanes on r_data 80FF_7F01.
        ld_ben = '{4'b0010, 4'b1000, 4'b1000, 4'b1100, 4'b1111, 4'b0001, 4'b0011, 4'b0100, 4'b0101};
        ld_sgn = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ld_exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01,
                   32'h0000_0001, 32'h0000_7F01, 32'hFFFF_FFFF, 32'h80FF_7F01};
        for (int i = 0; i < 9; i++) begin
            issue(mk(32'h1000_0100 + 32'(i * 4), 1'b1, ld_sgn[i], ld_ben[i], 5'(i + 1),
                     32'hDEAD_0000), 1'b1, ld_exp[i]);
        end

        // r0 destination: no write, trace record with we 0.
        issue(mk(32'h1000_0200, 1'b0, 1'b0, 4'b1111, 5'd0, 32'hCAFE_F00D), 1'b1, 32'hCAFE_F00D);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: A, B fill the FIFO, C stalls, then a streaming run at full.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        issue(mk(32'hA000_0000, 1'b0, 1'b0, 4'b1111, 5'd10, 32'h0000_000A), 1'b1, 32'h0000_000A);
        issue(mk(32'hB000_0000, 1'b0, 1'b0, 4'b1111, 5'd11, 32'h0000_000B), 1'b1, 32'h0000_000B);
        issue(mk(32'hC000_0000, 1'b0, 1'b0, 4'b1111, 5'd12, 32'h0000_000C), 1'b1, 32'h0000_000C);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    issue(mk(32'hD000_0000 + 32'(i * 4), 1'b0, 1'b0, 4'b1111, 5'(13 + i),
                             32'h0000_0D00 + 32'(i)), 1'b1, 32'h0000_0D00 + 32'(i));
                end
            end
            begin
                repeat (2) @(negedge clk);
                check("stall_allow_in", 73'(WB_allow_in), 73'(0));
                check("stall_rf_w_en", 73'(rf_w_en), 73'(0));
                check("stall_by_valid", 73'(WB_to_BY_bus[38]), 73'(1));
                check("stall_trace_head", 73'({trace_valid, trace_pc}), 73'({1'b1, 32'hA000_0000}));
                ready_mode = 1;
                @(negedge clk);
                check("unstall_rf_w_en", 73'(rf_w_en), 73'(1));
                check("unstall_allow_in", 73'(WB_allow_in), 73'(1));
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Async reset between edges while stalled discards everything.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            issue(mk(32'hE000_0000 + 32'(i * 4), 1'b0, 1'b0, 4'b1111, 5'(20 + i), 32'(i + 1)),
                  1'b1, 32'(i + 1));
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_by_valid", 73'(WB_to_BY_bus[38]), 73'(0));
        check("arst_rf_w_en", 73'(rf_w_en), 73'(0));
        check("arst_trace_valid", 73'(trace_valid), 73'(0));
        check("arst_allow_in", 73'(WB_allow_in), 73'(1));
        exp_rf_q.delete();
        exp_tr_q.delete();
        ready_mode = 1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(mk(32'hF000_0000, 1'b0, 1'b0, 4'b1111, 5'd7, 32'h7777_0007), 1'b1, 32'h7777_0007);
        @(negedge clk);
        check("post_rst_rf_w_en", 73'(rf_w_en), 73'(1));
        @(posedge clk);
        #1;

        // Random traffic with random consumer stalls.
        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(rand_instr(i), 1'b0, 32'h0);
        end

        ready_mode = 1;
        budget = 100;
        while ((exp_rf_q.size() != 0 || exp_tr_q.size() != 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check("drain_rf_q", 73'(exp_rf_q.size()), 73'(0));
        check("drain_trace_q", 73'(exp_tr_q.size()), 73'(0));
        @(negedge clk);
        check("idle_trace_valid", 73'(trace_valid), 73'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
